// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the IF/ID instruction queue: NOP encoding,
// PC increment and the queue-entry layout.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC    = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_queue_ptr.sv
// Read/write pointer and occupancy bookkeeping for the IF/ID queue.
// Pointers are log2(DEPTH) bits wide, so they wrap DEPTH-1 -> 0 naturally.
module if_id_queue_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_en,
    input  logic                       pop_en,
    input  logic                       flush,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Pointer advance and occupancy update; flush returns everything to empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= {PW{1'b0}};
            rd_ptr <= {PW{1'b0}};
            count  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr <= {PW{1'b0}};
            rd_ptr <= {PW{1'b0}};
            count  <= {CW{1'b0}};
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end else begin
                wr_ptr <= wr_ptr;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end else begin
                rd_ptr <= rd_ptr;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular buffer between fetch and decode.
// Define IF_ID_QUEUE_BYPASS_EN to present an offered instruction in the same cycle when empty.
module if_id_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         Instruction_if,
    input  logic [WIDTH-1:0]         PC_if,
    input  logic                     push,
    output logic                     push_ready,
    input  logic                     IF_flush,
    input  logic                     IDWrite,
    output logic [WIDTH-1:0]         Instruction_id,
    output logic [WIDTH-1:0]         PC4_id,
    output logic                     valid_id,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem    [DEPTH];

    logic [PW-1:0] wr_ptr_s;
    logic [PW-1:0] rd_ptr_s;
    logic [CW-1:0] count_s;
    logic          head_valid_s;
    logic          push_acc_s;
    logic          pop_s;
    logic          write_s;

    // Occupancy alone decides push_ready when empty, which keeps it free of the bypass path.
    assign head_valid_s = (count_s != {CW{1'b0}});
    assign push_ready   = (count_s < CW'(DEPTH)) | (IDWrite & head_valid_s);
    assign push_acc_s   = push & push_ready & ~IF_flush;
    assign pop_s        = IDWrite & head_valid_s & ~IF_flush;
    assign count        = count_s;

`ifdef IF_ID_QUEUE_BYPASS_EN
    // A bypassed word that decode consumes immediately never enters storage.
    assign write_s = push_acc_s & ~(~head_valid_s & IDWrite);
`else
    assign write_s = push_acc_s;
`endif

    if_id_queue_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk     (clk),
        .reset   (reset),
        .push_en (write_s),
        .pop_en  (pop_s),
        .flush   (IF_flush),
        .wr_ptr  (wr_ptr_s),
        .rd_ptr  (rd_ptr_s),
        .count   (count_s)
    );

    // Entry storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (write_s) begin
            instr_mem[wr_ptr_s] <= Instruction_if;
            pc_mem[wr_ptr_s]    <= PC_if;
        end else begin
            instr_mem[wr_ptr_s] <= instr_mem[wr_ptr_s];
            pc_mem[wr_ptr_s]    <= pc_mem[wr_ptr_s];
        end
    end

    // Head presentation: stored entry, optional empty bypass, otherwise NOP.
    always_comb begin
        Instruction_id = WIDTH'(NOP_INSTR);
        PC4_id         = {WIDTH{1'b0}};
        valid_id       = 1'b0;
        if (head_valid_s) begin
            Instruction_id = instr_mem[rd_ptr_s];
            PC4_id         = pc_mem[rd_ptr_s] + WIDTH'(PC_INC);
            valid_id       = 1'b1;
        end
`ifdef IF_ID_QUEUE_BYPASS_EN
        else if (push && !IF_flush) begin
            Instruction_id = Instruction_if;
            PC4_id         = PC_if + WIDTH'(PC_INC);
            valid_id       = 1'b1;
        end
`endif
        else begin
            Instruction_id = WIDTH'(NOP_INSTR);
            PC4_id         = {WIDTH{1'b0}};
            valid_id       = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4, WIDTH=32).
module tb_if_id_queue;

    logic        clk;
    logic        reset;
    logic [31:0] Instruction_if;
    logic [31:0] PC_if;
    logic        push;
    logic        push_ready;
    logic        IF_flush;
    logic        IDWrite;
    logic [31:0] Instruction_id;
    logic [31:0] PC4_id;
    logic        valid_id;
    logic [2:0]  count;

    int tests;
    int fails;

    if_id_queue #(.DEPTH(4), .WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .Instruction_if (Instruction_if),
        .PC_if          (PC_if),
        .push           (push),
        .push_ready     (push_ready),
        .IF_flush       (IF_flush),
        .IDWrite        (IDWrite),
        .Instruction_id (Instruction_id),
        .PC4_id         (PC4_id),
        .valid_id       (valid_id),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; IDWrite = 1'b0; IF_flush = 1'b0;
        Instruction_if = 32'h0; PC_if = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0; push = 1'b1;
        Instruction_if = 32'h2008_0005; PC_if = 32'h0;
        tick(); tick();
        tests++; if (valid_id !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b exp 0", valid_id); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
        tests++; if (Instruction_id !== 32'h0) begin fails++; $display("FAIL reset_instr got %h exp 0", Instruction_id); end
        #2 reset = 1'b1;
        tick();
        push = 1'b0;
        #1;
        tests++; if (Instruction_id !== 32'h2008_0005) begin fails++; $display("FAIL first_instr got %h exp 20080005", Instruction_id); end
        tests++; if (PC4_id !== 32'h4) begin fails++; $display("FAIL first_pc4 got %h exp 4", PC4_id); end
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL first_count got %0d exp 1", count); end
        IDWrite = 1'b1;
        tick();
        idle(); #1;
        tests++; if (count !== 3'd0 || valid_id !== 1'b0) begin fails++; $display("FAIL first_pop count %0d valid %0b exp 0/0", count, valid_id); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; Instruction_if = 32'hA0 + i; PC_if = 32'h100 + 4*i;
            tick();
        end
        idle(); #1;
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count got %0d exp 4", count); end
        tests++; if (push_ready !== 1'b0) begin fails++; $display("FAIL fill_ready got %0b exp 0", push_ready); end
        tests++; if (Instruction_id !== 32'hA0) begin fails++; $display("FAIL fill_head got %h exp a0", Instruction_id); end
        push = 1'b1; Instruction_if = 32'hEE; PC_if = 32'h200;
        tick();
        idle(); #1;
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL fifth_push count got %0d exp 4", count); end
        IDWrite = 1'b1; #1;
        tests++; if (push_ready !== 1'b1) begin fails++; $display("FAIL pop_ready got %0b exp 1", push_ready); end
        IDWrite = 1'b0;
    endtask

    task automatic test_full_push_pop();
        push = 1'b1; IDWrite = 1'b1; Instruction_if = 32'hA4; PC_if = 32'h110;
        tick();
        idle(); #1;
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL pp_count got %0d exp 4", count); end
        tests++; if (Instruction_id !== 32'hA1 || PC4_id !== 32'h108) begin fails++; $display("FAIL pp_head got %h/%h exp a1/108", Instruction_id, PC4_id); end
        for (int i = 1; i <= 4; i++) begin
            tests++; if (Instruction_id !== 32'hA0 + i) begin fails++; $display("FAIL drain_%0d got %h exp %h", i, Instruction_id, 32'hA0 + i); end
            IDWrite = 1'b1;
            tick();
            IDWrite = 1'b0; #1;
        end
        tests++; if (count !== 3'd0 || valid_id !== 1'b0) begin fails++; $display("FAIL drain_empty count %0d valid %0b", count, valid_id); end
        IDWrite = 1'b1;
        tick();
        IDWrite = 1'b0; #1;
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL empty_pop count got %0d exp 0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; Instruction_if = 32'hB0 + i; PC_if = 32'h300 + 4*i;
            tick();
        end
        idle(); #1;
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL preflush_count got %0d exp 3", count); end
        IF_flush = 1'b1; push = 1'b1; IDWrite = 1'b1; Instruction_if = 32'hBF; PC_if = 32'h3F0;
        tick();
        idle(); #1;
        tests++; if (count !== 3'd0 || valid_id !== 1'b0) begin fails++; $display("FAIL flush count %0d valid %0b exp 0/0", count, valid_id); end
        tick();
        tests++; if (count !== 3'd0 || Instruction_id !== 32'h0) begin fails++; $display("FAIL flush_absent count %0d instr %h", count, Instruction_id); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 10; k++) begin
            push = 1'b1; Instruction_if = 32'hC0 + k; PC_if = 4*k;
            IDWrite = (k > 0);
            #1;
            if (k > 0) begin
                tests++; if (PC4_id !== 4*k) begin fails++; $display("FAIL wrap_%0d pc4 got %h exp %h", k, PC4_id, 4*k); end
            end
            tick();
        end
        idle(); #1;
        tests++; if (PC4_id !== 32'd40 || count !== 3'd1) begin fails++; $display("FAIL wrap_last pc4 %h count %0d exp 28/1", PC4_id, count); end
        IDWrite = 1'b1;
        tick();
        IDWrite = 1'b0;
        push = 1'b1; Instruction_if = 32'hD0; PC_if = 32'hFFFF_FFFC;
        tick();
        idle(); #1;
        tests++; if (PC4_id !== 32'h0 || valid_id !== 1'b1) begin fails++; $display("FAIL pc_wrap pc4 %h valid %0b exp 0/1", PC4_id, valid_id); end
        IDWrite = 1'b1;
        tick();
        idle(); #1;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            push = 1'b1; Instruction_if = 32'hE0 + i; PC_if = 32'h500 + 4*i;
            tick();
        end
        idle();
        #2 reset = 1'b0;
        #1;
        tests++; if (count !== 3'd0 || valid_id !== 1'b0 || PC4_id !== 32'h0) begin fails++; $display("FAIL mid_reset count %0d valid %0b pc4 %h", count, valid_id, PC4_id); end
        #1 reset = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        push = 1'b1; IDWrite = 1'b1; Instruction_if = 32'h8C22_0000; PC_if = 32'h40;
        #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
        tests++; if (valid_id !== 1'b1 || Instruction_id !== 32'h8C22_0000 || PC4_id !== 32'h44) begin fails++; $display("FAIL bypass_out valid %0b instr %h pc4 %h", valid_id, Instruction_id, PC4_id); end
        tick();
        idle(); #1;
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL bypass_count got %0d exp 0", count); end
`else
        tests++; if (valid_id !== 1'b0 || Instruction_id !== 32'h0) begin fails++; $display("FAIL nobypass_out valid %0b instr %h exp 0/0", valid_id, Instruction_id); end
        tick();
        idle(); #1;
        tests++; if (count !== 3'd1 || Instruction_id !== 32'h8C22_0000) begin fails++; $display("FAIL nobypass_stored count %0d instr %h", count, Instruction_id); end
        IDWrite = 1'b1;
        tick();
        idle(); #1;
`endif
    endtask

    initial begin
        clk = 1'b0;
        tests = 0;
        fails = 0;
        idle();
        test_reset();
        test_fill();
        test_full_push_pop();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 Parameter WIDTH, default 32, instruction/PC width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 Instruction_if  input  WIDTH  fetched instruction from fetch stage.
REQ-006 PC_if  input  WIDTH  address of Instruction_if.
REQ-007 push  input  1  fetch offers Instruction_if/PC_if this cycle.
REQ-008 push_ready  output  1  queue accepts push this cycle; fetch gates IFWrite with it.
REQ-009 IF_flush  input  1  jump/branch redirect; discards queued and offered instructions.
REQ-010 IDWrite  input  1  decode consumes head entry this cycle (pop).
REQ-011 Instruction_id  output  WIDTH  head instruction; 0 (NOP) when empty.
REQ-012 PC4_id  output  WIDTH  head PC + 4; 0 when empty.
REQ-013 valid_id  output  1  head entry valid.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Storage SHALL be a circular buffer with read/write pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-016 push_ready SHALL be (count < DEPTH) | (IDWrite & valid_id); combinational.
REQ-017 Push accepted when push & push_ready & ~IF_flush; entry written at write pointer, write pointer increments.
REQ-018 Pop occurs when IDWrite & valid_id & ~IF_flush; read pointer increments; IDWrite with queue empty SHALL be ignored.
REQ-019 Simultaneous accepted push and pop: count unchanged, both pointers advance; legal when full.
REQ-020 IF_flush SHALL, next edge, set count=0, pointers=0; same-cycle push and pop SHALL be dropped.
REQ-021 Default latency: pushed entry visible at Instruction_id/valid_id one cycle after accepting edge.
REQ-022 Instruction_id, PC4_id, valid_id SHALL be driven from head entry; when count==0 they SHALL be 0.
REQ-023 PC4_id SHALL be stored PC + 4, modulo 2^WIDTH (0xFFFFFFFC -> 0x00000000).
REQ-024 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-025 reset low SHALL immediately clear count, pointers, valid_id, Instruction_id, PC4_id to 0, independent of clk.
REQ-026 Assertion mid-operation SHALL discard all entries; storage array contents need not be cleared.
REQ-027 First push accepted on first rising edge after reset deasserts.

Configuration
REQ-028 Macro IF_ID_QUEUE_BYPASS_EN SHALL enable empty-queue bypass.
REQ-029 With macro: when count==0, push & ~IF_flush, outputs SHALL show Instruction_if/PC_if+4 with valid_id=1 in the same cycle; if IDWrite also high, entry SHALL not be written.
REQ-030 Without macro: no combinational path from push-side inputs to Instruction_id/PC4_id/valid_id; REQ-021 latency holds.

Structure
REQ-031 Shared package (cpu_pkg) SHALL hold NOP constant (32'h0), PC increment constant (4), and the queue-entry struct {instr, pc}.
REQ-032 One sub-module natural: if_id_queue_ptr (pointer/count bookkeeping, wrap logic); storage and output mux stay in top.

Verification
REQ-033 Reset: hold reset low, push=1 -> valid_id=0, count=0, Instruction_id=0; release, push 0x20080005@PC 0 -> next cycle Instruction_id=0x20080005, PC4_id=4.
REQ-034 Fill: 4 pushes, IDWrite=0 -> count=4, push_ready=0; 5th push not accepted; pop -> push_ready=1.
REQ-035 Full push+pop same cycle: count stays 4, head advances to entry 2, new entry lands at tail.
REQ-036 Flush: count=3, IF_flush=1 with push=1, IDWrite=1 -> next cycle count=0, valid_id=0, pushed word absent.
REQ-037 Wrap: 10 push/pop cycles PC 0..36 -> PC4_id sequence 4..40 in order, no loss/duplication; PC 0xFFFFFFFC -> PC4_id 0.
REQ-038 Bypass (macro on): empty, push 0x8C220000 with IDWrite=1 -> same cycle valid_id=1, Instruction_id=0x8C220000, next cycle count=0; macro off -> valid_id=0 that cycle.
